// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
module uart_tx_mmio #(
  parameter int FIFO_DEPTH     = 8,
  parameter int BAUD_DIV_RESET = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud_div, frame_div, baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  logic sel_data, sel_status, sel_baud;
  logic fifo_empty, fifo_full, push, pop, cnt_zero, busy;
  logic unused_bits;

  assign sel_data   = we && (a[3:2] == 2'd0);
  assign sel_status = we && (a[3:2] == 2'd1);
  assign sel_baud   = we && (a[3:2] == 2'd2);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a push.
  assign push       = sel_data && !fifo_full;
  assign cnt_zero   = (baud_cnt == 16'd0);
  assign busy       = (state_q != IDLE);
  assign unused_bits = ^{a[31:4], a[1:0], wd[31:16]};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (cnt_zero) state_d = DATA;
      DATA:  if (cnt_zero && bit_cnt == 3'd7) state_d = STOP;
      STOP: begin
        if (cnt_zero) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= 16'(BAUD_DIV_RESET);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (sel_data && fifo_full)     overflow <= 1'b1;
      else if (sel_status && wd[3])  overflow <= 1'b0;
      if (sel_baud) baud_div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    end
  end

  // Divisor is captured per frame so mid-frame BAUDDIV writes wait for the next byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift     <= 8'd0;
      frame_div <= 16'd1;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
    end else if (pop) begin
      shift     <= mem[rd_ptr];
      frame_div <= baud_div;
      baud_cnt  <= baud_div - 16'd1;
      bit_cnt   <= 3'd0;
    end else if (busy) begin
      if (cnt_zero) begin
        baud_cnt <= frame_div - 16'd1;
        if (state_q == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    rd = 32'd0;
    case (a[3:2])
      2'd1:    rd = {23'd0, 5'(count), overflow, fifo_full, fifo_empty, busy};
      2'd2:    rd = {16'd0, baud_div};
      default: rd = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam logic [31:0] DATA_A = 32'h0000_1010;
  localparam logic [31:0] STAT_A = 32'h0000_1014;
  localparam logic [31:0] BAUD_A = 32'h0000_1018;
  localparam logic [31:0] RSV_A  = 32'h0000_101C;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;

  int total = 0;
  int bad   = 0;
  logic [7:0]  bytes_q [16];
  logic [31:0] val;

  uart_tx_mmio dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .tx    (tx)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; performs one store on the next edge and returns at the following negedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    a  = STAT_A;
    wd = $urandom;
    @(negedge clk);
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] v);
    a = addr;
    #1;
    v = rd;
    a = STAT_A;
  endtask

  // Writes bytes_q[0..n-1] on consecutive edges and checks tx/busy/count/empty every cycle
  // against frame arithmetic: frame i occupies cycles k+1+10*d*i .. k+10*d*(i+1).
  task automatic run_stream(input int d, input int n);
    for (int t = 0; t <= 10 * d * n + 2; t++) begin
      int rel, fi, bi, pushed, popped, exp_cnt;
      logic exp_tx, exp_busy;
      if (t < n) begin
        we = 1'b1;
        a  = {16'($urandom), 12'h101, 2'b00, 2'($urandom)};
        wd = {24'($urandom), bytes_q[t]};
      end
      @(posedge clk);
      #1;
      we = 1'b0;
      a  = STAT_A;
      #1;
      rel = t - 1;
      if (rel >= 0 && rel < 10 * d * n) begin
        fi = rel / (10 * d);
        bi = (rel % (10 * d)) / d;
        exp_busy = 1'b1;
        if (bi == 0)      exp_tx = 1'b0;
        else if (bi == 9) exp_tx = 1'b1;
        else              exp_tx = bytes_q[fi][bi-1];
      end else begin
        exp_busy = 1'b0;
        exp_tx   = 1'b1;
      end
      pushed  = (t + 1 < n) ? t + 1 : n;
      popped  = (rel < 0) ? 0 : ((rel / (10 * d) + 1 < n) ? rel / (10 * d) + 1 : n);
      exp_cnt = pushed - popped;
      chk("stream_tx",    32'(tx),     32'(exp_tx));
      chk("stream_busy",  32'(rd[0]),  32'(exp_busy));
      chk("stream_count", 32'(rd[8:4]), 32'(exp_cnt));
      chk("stream_empty", 32'(rd[1]),  32'(exp_cnt == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    a     = STAT_A;
    wd    = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_tx_low", 32'(tx), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    rdreg(STAT_A, val); chk("reset_status", val, 32'h2);
    rdreg(BAUD_A, val); chk("reset_baud", val, 32'd434);
    chk("reset_tx", 32'(tx), 32'd1);

    rdreg(RSV_A, val);  chk("rsv_read", val, 32'd0);
    rdreg(DATA_A, val); chk("data_read", val, 32'd0);
    wr(RSV_A, 32'hFFFF_FFFF);
    rdreg(STAT_A, val); chk("rsv_write_status", val, 32'h2);
    rdreg(BAUD_A, val); chk("rsv_write_baud", val, 32'd434);
    wr(BAUD_A, 32'hABCD_0005);
    rdreg(BAUD_A, val); chk("baud_upper", val, 32'd5);
    wr(BAUD_A, 32'h0000_0000);
    rdreg(BAUD_A, val); chk("baud_zero", val, 32'd1);

    wr(BAUD_A, 32'd4);
    bytes_q[0] = 8'h55;
    run_stream(4, 1);

    wr(BAUD_A, 32'd2);
    bytes_q[0] = 8'hA5;
    bytes_q[1] = 8'h3C;
    run_stream(2, 2);

    for (int r = 0; r < 5; r++) begin
      int d, n;
      d = $urandom_range(1, 4);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) bytes_q[i] = 8'($urandom);
      wr(BAUD_A, 32'(d));
      run_stream(d, n);
    end

    wr(BAUD_A, 32'd3);
    for (int t = 0; t <= 92; t++) begin
      logic exp_tx, exp_busy;
      we = 1'b0;
      if (t == 0)  begin we = 1'b1; a = DATA_A; wd = 32'h0000_00FF; end
      if (t == 1)  begin we = 1'b1; a = DATA_A; wd = 32'h0000_0000; end
      if (t == 10) begin we = 1'b1; a = BAUD_A; wd = 32'd6; end
      @(posedge clk);
      #1;
      we = 1'b0;
      a  = STAT_A;
      #1;
      exp_tx   = !((t >= 1 && t <= 3) || (t >= 31 && t <= 84));
      exp_busy = (t >= 1 && t <= 90);
      chk("divchg_tx",   32'(tx),    32'(exp_tx));
      chk("divchg_busy", 32'(rd[0]), 32'(exp_busy));
      @(negedge clk);
    end

    wr(BAUD_A, 32'd1000);
    for (int i = 0; i < 10; i++) wr(DATA_A, {24'($urandom), 8'($urandom)});
    rdreg(STAT_A, val); chk("ovf_status", val, 32'h8D);
    wr(STAT_A, 32'h7);
    rdreg(STAT_A, val); chk("ovf_keep", val, 32'h8D);
    wr(STAT_A, 32'h8);
    rdreg(STAT_A, val); chk("ovf_clear", val, 32'h85);
    chk("pre_abort_tx", 32'(tx), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    rdreg(STAT_A, val); chk("abort_status", val, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rdreg(STAT_A, val); chk("post_abort_status", val, 32'h2);
    rdreg(BAUD_A, val); chk("post_abort_baud", val, 32'd434);
    repeat (3) @(negedge clk);
    chk("post_abort_tx", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter with an 8-entry byte FIFO. It occupies the I/O window at 0x00001010–0x0000101F, next to the existing switch/LED/7-segment I/O unit. The top-level address decoder gives it qualified store strobes and routes its read data into the processor's ReadData multiplexer. It serialises queued bytes onto a single `tx` line in 8N1 format at a software-programmable bit period.

## Interface
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2–16.
- BAUD_DIV_RESET, 434: reset bit period in clk cycles (50 MHz / 115200).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- we  in  1  store strobe, already qualified by the top-level decode (MemWrite && address in window).
- a  in  32  byte address; only a[3:2] is decoded, all other bits ignored.
- wd  in  32  store data.
- rd  out  32  combinational read data for register a[3:2].
- tx  out  1  serial output; idle high.

## Operation
- Register map (offset from 0x00001010, selected by a[3:2]):
  - 0x0 DATA. Write pushes wd[7:0]. Reads 0.
  - 0x4 STATUS. Read: bit0 busy (FSM not IDLE), bit1 fifo_empty, bit2 fifo_full, bit3 overflow (sticky), bits[8:4] fifo count 0..FIFO_DEPTH, other bits 0. Writing wd[3]=1 clears overflow; other bits are ignored.
  - 0x8 BAUDDIV. R/W in bits[15:0]; upper bits read 0. A written value of 0 is stored as 1.
  - 0xC reserved. Reads 0; writes are ignored.
- Store width is not decoded: every store to DATA uses wd[7:0].
- FIFO:
  - Circular buffer with read pointer, write pointer and count.
  - A push while full is dropped and sets overflow. A same-edge pop does not rescue it, because full is evaluated on the pre-edge count.
  - Push and pop on the same edge when not full: count is unchanged and both pointers advance.
- TX FSM states are IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter are latched with BAUDDIV at the start of each frame.
  - IDLE: tx=1. If FIFO is not empty, pop the head into the shift register, latch the divisor, go to START.
  - START: tx=0 for div cycles, then go to DATA.
  - DATA: tx=shift[0] for div cycles, then shift right. After bit 7, go to STOP. Bits go out LSB first.
  - STOP: tx=1 for div cycles. If FIFO is not empty, pop the next byte and go straight to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Writing BAUDDIV mid-frame does not affect the frame in progress; the new value applies from the next frame.
- Reset mid-frame aborts the frame: tx returns to 1 asynchronously and the FIFO contents are discarded.

## Timing
- Reset values:
  - tx=1, state IDLE, FIFO empty (count 0), overflow 0, BAUDDIV=BAUD_DIV_RESET.
  - rd therefore reads STATUS = 0x00000002.
- rd is combinational from a and register state, with zero-cycle read latency, matching the dmem/io read path.
- Write latency: register and FIFO state change on the edge where we=1. The value is visible on rd from the next cycle.
- Start latency, FIFO empty and IDLE:
  - DATA is written at edge k.
  - The FSM pops at edge k+1, and tx drops after k+1.
  - busy reads 1 from cycle k+1.
- Frame length is exactly 10·div cycles. Back-to-back frames have no gap.
- The pop at the STOP→START edge frees a slot on that same edge. fifo_full deasserts on the following cycle.

## Test plan
- Reset: hold reset=0 mid-frame → tx=1 immediately, and STATUS reads 0x00000002 after release.
- Single byte, BAUDDIV=4, write DATA=0x55 at edge k → tx low for cycles k+1..k+4, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high for 4 cycles. busy clears at k+41.
- Back-to-back, BAUDDIV=2, write 0xA5 then 0x3C on consecutive cycles → two 20-cycle frames with no idle gap, count reads 1 after the first pop, and busy stays high for 40 cycles.
- Overflow, BAUDDIV=1000, write 10 bytes → count=8 (first byte popped, 8 queued), one byte dropped, STATUS bit3=1. Write STATUS=0x8 → bit3=0 with count unchanged.
- Divisor change mid-frame: BAUDDIV=3, send 0xFF, write BAUDDIV=6 during DATA → current frame is 30 cycles and the next frame is 60 cycles. Writing BAUDDIV=0 reads back 1.
- Decode: read 0xC and DATA → 0. A write to 0xC has no effect, and sb versus sw to DATA produce an identical byte.
